// File: rtl/inst_queue.sv
// inst_queue: show-ahead circular instruction buffer between fetch and decode
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  input  logic             in_adel,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic             out_adel,
  input  logic             out_ready,
  input  logic             flush,
  output logic [PTR_W:0]   count
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [64:0] mem [DEPTH];
  logic [PTR_W-1:0] rptr, wptr;
  logic push, pop;
  assign in_ready  = count < FULL;
  assign out_valid = count != '0;
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;
  // Head is gated to zero when empty so decode sees a NOP bubble, not stale storage
  assign {out_pc, out_instr, out_adel} = out_valid ? mem[rptr] : 65'h0;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {in_pc, in_instr, in_adel};
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop) rptr <= rptr + PTR_W'(1);
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end
endmodule
